// File: rtl/diff_operand_fetch.sv
// Operand-fetch stage in front of the diff/equality unit: register file, writeback forwarding, one output register.
// Optional RAW interlock on in-flight destinations is enabled with `define DIFF_FETCH_SCOREBOARD_EN.
module diff_operand_fetch #(
    parameter int DATA_W    = 32,
    parameter int REG_COUNT = 32,
    parameter int ADDR_W    = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] opnd1,
    output logic [DATA_W-1:0] opnd2,
    output logic [ADDR_W-1:0] out_rd
);

    logic [DATA_W-1:0] regs_r [REG_COUNT];
    logic              out_valid_r;
    logic [DATA_W-1:0] opnd1_r;
    logic [DATA_W-1:0] opnd2_r;
    logic [ADDR_W-1:0] out_rd_r;

    logic              in_ready_s;
    logic              in_fire_s;
    logic              out_fire_s;
    logic              wb_ok_s;
    logic [DATA_W-1:0] rs_val_s;
    logic [DATA_W-1:0] rt_val_s;

    // Register 0 and out-of-range addresses are never stored or forwarded.
    function automatic logic addr_writable(input logic [ADDR_W-1:0] a);
        return (a != {ADDR_W{1'b0}}) && (32'(a) < 32'(REG_COUNT));
    endfunction

    assign wb_ok_s    = wb_en && addr_writable(wb_addr);
    assign in_fire_s  = in_valid && in_ready_s;
    assign out_fire_s = out_valid_r && out_ready;

    // Source read mux; a matching writeback in the same cycle overrides the stored value.
    always_comb begin
        rs_val_s = {DATA_W{1'b0}};
        rt_val_s = {DATA_W{1'b0}};
        for (int i = 1; i < REG_COUNT; i++) begin
            rs_val_s = (rs_addr == ADDR_W'(i)) ? regs_r[i] : rs_val_s;
            rt_val_s = (rt_addr == ADDR_W'(i)) ? regs_r[i] : rt_val_s;
        end
        rs_val_s = (wb_ok_s && (wb_addr == rs_addr)) ? wb_data : rs_val_s;
        rt_val_s = (wb_ok_s && (wb_addr == rt_addr)) ? wb_data : rt_val_s;
    end

`ifdef DIFF_FETCH_SCOREBOARD_EN
    logic [REG_COUNT-1:0] pending_r;
    logic                 hazard_s;

    // A source is blocked while its producer is in flight, unless it retires this cycle (then forwarding covers it).
    always_comb begin
        hazard_s = 1'b0;
        for (int i = 1; i < REG_COUNT; i++) begin
            hazard_s = hazard_s
                     | (pending_r[i]
                        && !(wb_en && (wb_addr == ADDR_W'(i)))
                        && ((rs_addr == ADDR_W'(i)) || (rt_addr == ADDR_W'(i))));
        end
    end

    assign in_ready_s = (!out_valid_r || out_ready) && !hazard_s;

    // Pending set on issue of rd, cleared on writeback; a same-cycle set wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_r <= {REG_COUNT{1'b0}};
        end else begin
            pending_r[0] <= 1'b0;
            for (int i = 1; i < REG_COUNT; i++) begin
                if (in_fire_s && (rd_addr == ADDR_W'(i))) begin
                    pending_r[i] <= 1'b1;
                end else if (wb_en && (wb_addr == ADDR_W'(i))) begin
                    pending_r[i] <= 1'b0;
                end else begin
                    pending_r[i] <= pending_r[i];
                end
            end
        end
    end
`else
    assign in_ready_s = !out_valid_r || out_ready;
`endif

    // Architectural register file; entry 0 stays zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
        end else begin
            regs_r[0] <= {DATA_W{1'b0}};
            for (int i = 1; i < REG_COUNT; i++) begin
                if (wb_ok_s && (wb_addr == ADDR_W'(i))) begin
                    regs_r[i] <= wb_data;
                end else begin
                    regs_r[i] <= regs_r[i];
                end
            end
        end
    end

    // Output register: operands are captured at fetch and held through stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            opnd1_r     <= {DATA_W{1'b0}};
            opnd2_r     <= {DATA_W{1'b0}};
            out_rd_r    <= {ADDR_W{1'b0}};
        end else if (in_fire_s) begin
            out_valid_r <= 1'b1;
            opnd1_r     <= rs_val_s;
            opnd2_r     <= rt_val_s;
            out_rd_r    <= rd_addr;
        end else if (out_fire_s) begin
            out_valid_r <= 1'b0;
            opnd1_r     <= opnd1_r;
            opnd2_r     <= opnd2_r;
            out_rd_r    <= out_rd_r;
        end else begin
            out_valid_r <= out_valid_r;
            opnd1_r     <= opnd1_r;
            opnd2_r     <= opnd2_r;
            out_rd_r    <= out_rd_r;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign opnd1     = opnd1_r;
    assign opnd2     = opnd2_r;
    assign out_rd    = out_rd_r;

endmodule

// File: tb/tb_diff_operand_fetch.sv
// Directed bench for diff_operand_fetch: expected operands are queued at input fire and checked by an output monitor.
module tb_diff_operand_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [4:0]  rd_addr;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] opnd1;
    logic [31:0] opnd2;
    logic [4:0]  out_rd;

    diff_operand_fetch #(.DATA_W(32), .REG_COUNT(32), .ADDR_W(5)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .opnd1(opnd1), .opnd2(opnd2), .out_rd(out_rd)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] o1;
        logic [31:0] o2;
        logic [4:0]  rd;
        int          fc;
    } exp_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    bit          front_seen = 1'b0;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp1;
    logic [31:0] exp2;
    logic [31:0] m [32];

    logic [4:0]  tp_rs [8] = '{5'd5, 5'd6, 5'd7, 5'd1, 5'd0, 5'd3, 5'd6, 5'd5};
    logic [4:0]  tp_rt [8] = '{5'd6, 5'd7, 5'd1, 5'd0, 5'd3, 5'd5, 5'd5, 5'd7};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // Scoreboard: compare presented output against the queue head, then record any fire happening this cycle.
    always @(negedge clk) begin
        if (rst) begin
            sbq.delete();
            front_seen = 1'b0;
        end else begin
            chk("out_valid", {31'd0, out_valid}, (sbq.size() != 0) ? 32'd1 : 32'd0);
            if (out_valid && (sbq.size() != 0)) begin
                mon_e = sbq[0];
                if (!front_seen) begin
                    chk("latency", 32'(cyc - mon_e.fc), 32'd1);
                    front_seen = 1'b1;
                end
                chk("opnd1", opnd1, mon_e.o1);
                chk("opnd2", opnd2, mon_e.o2);
                chk("out_rd", {27'd0, out_rd}, {27'd0, mon_e.rd});
                if (out_ready) begin
                    void'(sbq.pop_front());
                    front_seen = 1'b0;
                end
            end
            if (in_valid && in_ready) begin
                sbq.push_back('{o1: exp1, o2: exp2, rd: rd_addr, fc: cyc});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
        wb_en = 1'b1; wb_addr = a; wb_data = d;
        if (a != 5'd0) m[a] = d;
        step();
        wb_en = 1'b0;
    endtask

    task automatic issue(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic [31:0] e1, input logic [31:0] e2);
        logic ok;
        rs_addr = rs; rt_addr = rt; rd_addr = rd;
        exp1 = e1; exp2 = e2;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            ok = in_ready;
            step();
        end
        chk("issue_handshake", {31'd0, ok}, 32'd1);
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 32; i++) m[i] = 32'd0;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        rs_addr = 5'd0; rt_addr = 5'd0; rd_addr = 5'd0;
        wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
        exp1 = 32'd0; exp2 = 32'd0;
        repeat (2) step();
        rst = 1'b0;

        // Put state in the machine, then reset with a held instruction and a concurrent write.
        wb_write(5'd3, 32'h0000_0055);
        out_ready = 1'b0;
        issue(5'd3, 5'd3, 5'd1, 32'h0000_0055, 32'h0000_0055);
        rst = 1'b1;
        wb_en = 1'b1; wb_addr = 5'd8; wb_data = 32'h0000_0077;
        repeat (2) step();
        rst = 1'b0; wb_en = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 32; i++) m[i] = 32'd0;

        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_opnd1", opnd1, 32'd0);
        chk("rst_opnd2", opnd2, 32'd0);
        chk("rst_out_rd", {27'd0, out_rd}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        step();

        issue(5'd3, 5'd0, 5'd4, 32'd0, 32'd0);
        issue(5'd8, 5'd3, 5'd2, 32'd0, 32'd0);
        step();

        // Write then read, including a dropped write to register 0.
        wb_write(5'd5, 32'h0000_00F0);
        wb_write(5'd6, 32'h0000_00F1);
        wb_write(5'd0, 32'hFFFF_FFFF);
        issue(5'd5, 5'd6, 5'd10, 32'h0000_00F0, 32'h0000_00F1);
        issue(5'd0, 5'd5, 5'd11, 32'd0, 32'h0000_00F0);

        // Same-cycle forwarding, then the stored value.
        wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'hDEAD_BEEF; m[7] = 32'hDEAD_BEEF;
        issue(5'd7, 5'd7, 5'd12, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        wb_en = 1'b0;
        issue(5'd7, 5'd0, 5'd13, 32'hDEAD_BEEF, 32'd0);
        step();

        // Back-pressure: held operands ignore a later writeback; release fires the waiting instruction.
        wb_write(5'd1, 32'h0000_0011);
        out_ready = 1'b0;
        issue(5'd1, 5'd5, 5'd14, 32'h0000_0011, 32'h0000_00F0);
        rs_addr = 5'd1; rt_addr = 5'd0; rd_addr = 5'd15;
        exp1 = 32'h0000_0022; exp2 = 32'd0; in_valid = 1'b1;
        wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'h0000_0022; m[1] = 32'h0000_0022;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
            step();
            wb_en = 1'b0;
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("release_in_ready", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        step();

        // Back-to-back throughput.
        for (int k = 0; k < 8; k++) begin
            issue(tp_rs[k], tp_rt[k], 5'(16 + k), m[tp_rs[k]], m[tp_rt[k]]);
        end
        step();

        // Read-after-write on an in-flight destination.
        wb_write(5'd9, 32'h0000_0099);
        issue(5'd0, 5'd0, 5'd9, 32'd0, 32'd0);
        rs_addr = 5'd9; rt_addr = 5'd0; rd_addr = 5'd20; exp2 = 32'd0; in_valid = 1'b1;
`ifdef DIFF_FETCH_SCOREBOARD_EN
        exp1 = 32'h0000_1234;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("raw_stall_in_ready", {31'd0, in_ready}, 32'd0);
            step();
        end
        wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h0000_1234; m[9] = 32'h0000_1234;
        @(negedge clk);
        chk("raw_release_in_ready", {31'd0, in_ready}, 32'd1);
        step();
        wb_en = 1'b0; in_valid = 1'b0;
`else
        exp1 = 32'h0000_0099;
        @(negedge clk);
        chk("raw_no_interlock_in_ready", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        wb_write(5'd9, 32'h0000_1234);
`endif
        issue(5'd9, 5'd9, 5'd21, 32'h0000_1234, 32'h0000_1234);
        repeat (3) step();
        @(negedge clk);
        chk("drained", 32'(sbq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
